irq_pending_arbiter: RTL and testbench



---
 rtl/irq_pkg.sv | 12 +
 rtl/irq_pending_arbiter_if.sv | 26 ++
 rtl/irq_prio_enc.sv | 20 ++
 rtl/irq_pending_arbiter.sv | 115 +++++++++++
 tb/tb_irq_pending_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt pending/arbitration slice.
package irq_pkg;

  localparam int unsigned CAUSE_W_DEF = 5;
  localparam int unsigned NSRC_MAX    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } irq_state_e;

endpackage : irq_pkg

// File: rtl/irq_pending_arbiter_if.sv
// Source/enable/ack inputs and presented-interrupt outputs of the pending arbiter.
interface irq_pending_arbiter_if
  import irq_pkg::*;
#(
  parameter int unsigned NSRC    = 8,
  parameter int unsigned CAUSE_W = CAUSE_W_DEF
);

  logic [NSRC-1:0]    io_irq_src;
  logic [NSRC-1:0]    io_irq_en;
  logic               io_irq_ack;
  logic               io_irq;
  logic [CAUSE_W-1:0] io_irq_cause;
  logic [NSRC-1:0]    io_irq_pending;

  modport master (
    output io_irq_src, io_irq_en, io_irq_ack,
    input  io_irq, io_irq_cause, io_irq_pending
  );

  modport slave (
    input  io_irq_src, io_irq_en, io_irq_ack,
    output io_irq, io_irq_cause, io_irq_pending
  );

endinterface : irq_pending_arbiter_if

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder over a request vector.
module irq_prio_enc #(
  parameter int unsigned NSRC    = 8,
  parameter int unsigned CAUSE_W = 5
) (
  input  logic [NSRC-1:0]    req,
  output logic               any,
  output logic [CAUSE_W-1:0] index
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    any   = |req;
    index = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (req[i]) index = CAUSE_W'(i);
    end
  end

endmodule : irq_prio_enc

// File: rtl/irq_pending_arbiter.sv
// Edge-detects interrupt sources into pending bits and presents the lowest enabled one
// until acknowledged. Define IRQ_PENDING_ARBITER_SYNC_EN to add a 2-flop input synchronizer.
module irq_pending_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned NSRC    = 8,
  parameter int unsigned CAUSE_W = CAUSE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  irq_pending_arbiter_if.slave  bus
);

  logic [NSRC-1:0]    line;
  logic [NSRC-1:0]    src_q, src_d;
  logic [NSRC-1:0]    pending_q, pending_d;
  logic [CAUSE_W-1:0] sel_q, sel_d;
  logic               irq_q, irq_d;
  irq_state_e         state_q, state_d;

  logic [NSRC-1:0]    rise;
  logic [NSRC-1:0]    clr;
  logic [NSRC-1:0]    sel_mask;
  logic               sel_en;
  logic               req_any;
  logic [CAUSE_W-1:0] req_idx;

`ifdef IRQ_PENDING_ARBITER_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync1_d;
  logic [NSRC-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.io_irq_src;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign line = sync2_q;
`else
  assign line = bus.io_irq_src;
`endif

  irq_prio_enc #(
    .NSRC    (NSRC),
    .CAUSE_W (CAUSE_W)
  ) u_prio_enc (
    .req   (pending_q & bus.io_irq_en),
    .any   (req_any),
    .index (req_idx)
  );

  // Shift instead of indexing so a wide sel never trips width checks on small NSRC.
  assign sel_mask = NSRC'(1) << sel_q;
  assign sel_en   = |(bus.io_irq_en & sel_mask);

  always_comb begin
    src_d   = line;
    rise    = line & ~src_q;
    clr     = '0;
    state_d = state_q;
    sel_d   = sel_q;

    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          sel_d   = req_idx;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.io_irq_ack) begin
          clr     = sel_mask;
          state_d = IDLE;
        end else if (!sel_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new edge on the bit being acked re-pends it.
    pending_d = (pending_q & ~clr) | rise;
    irq_d     = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pending_q <= '0;
      sel_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.io_irq         = irq_q;
  assign bus.io_irq_cause   = sel_q;
  assign bus.io_irq_pending = pending_q;

endmodule : irq_pending_arbiter

// File: tb/tb_irq_pending_arbiter.sv
// Self-checking bench for irq_pending_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_irq_pending_arbiter;

  localparam int unsigned NSRC    = 8;
  localparam int unsigned CAUSE_W = 5;
  localparam int unsigned VW      = 1 + CAUSE_W + NSRC;
`ifdef IRQ_PENDING_ARBITER_SYNC_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  irq_pending_arbiter_if #(.NSRC(NSRC), .CAUSE_W(CAUSE_W)) bus ();

  irq_pending_arbiter #(.NSRC(NSRC), .CAUSE_W(CAUSE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: "presenting" flag, selected index, pending set, last seen lines.
  logic [NSRC-1:0] m_prev = '0;
  logic [NSRC-1:0] m_pend = '0;
  logic [NSRC-1:0] m_s1   = '0;
  logic [NSRC-1:0] m_s2   = '0;
  bit              m_busy = 1'b0;
  int              m_sel  = 0;

  function automatic logic [VW-1:0] model_vec();
    return {m_busy, CAUSE_W'(m_sel), m_pend};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.io_irq, bus.io_irq_cause, bus.io_irq_pending};
  endfunction

  task automatic model_edge();
    logic [NSRC-1:0] seen, rise, avail;
    int lowest;
    if (reset) begin
      m_prev = '0; m_pend = '0; m_s1 = '0; m_s2 = '0; m_busy = 1'b0; m_sel = 0;
      return;
    end
`ifdef IRQ_PENDING_ARBITER_SYNC_EN
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = bus.io_irq_src;
`else
    seen = bus.io_irq_src;
`endif
    rise   = seen & ~m_prev;
    m_prev = seen;
    avail  = m_pend & bus.io_irq_en;
    if (m_busy) begin
      if (bus.io_irq_ack) begin
        m_pend[m_sel] = 1'b0;
        m_busy = 1'b0;
      end else if (!bus.io_irq_en[m_sel]) begin
        m_busy = 1'b0;
      end
    end else if (avail != 0) begin
      lowest = -1;
      for (int i = 0; i < int'(NSRC); i++) if (avail[i] && lowest < 0) lowest = i;
      m_sel  = lowest;
      m_busy = 1'b1;
    end
    m_pend = m_pend | rise;
  endtask

  // Advance one clock; the model follows the edge, outputs settle by the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.io_irq_src = '0; bus.io_irq_en = '0; bus.io_irq_ack = 1'b0;
    step(); step();
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_bad++; $display("FAIL reset_state got %h exp %h", dut_vec(), {VW{1'b0}});
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++; $display("FAIL reset_release got %h exp %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_single();
    int lat = 0;
    bus.io_irq_en = '1; bus.io_irq_src = 8'h08;
    for (int i = 0; i < 8; i++) begin
      step(); lat++;
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL single_model got %h exp %h", dut_vec(), model_vec());
      end
      if (bus.io_irq === 1'b1) break;
    end
    n_cmp++;
    if (bus.io_irq !== 1'b1 || lat != EXP_LAT || bus.io_irq_cause !== CAUSE_W'(3)) begin
      n_bad++; $display("FAIL single_latency irq=%b lat=%0d cause=%0d exp irq=1 lat=%0d cause=3", bus.io_irq, lat, bus.io_irq_cause, EXP_LAT);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({bus.io_irq, bus.io_irq_cause} !== {1'b1, CAUSE_W'(3)}) begin
        n_bad++; $display("FAIL single_hold cyc=%0d got irq=%b cause=%0d exp irq=1 cause=3", i, bus.io_irq, bus.io_irq_cause);
      end
    end
    bus.io_irq_ack = 1'b1; step(); bus.io_irq_ack = 1'b0;
    n_cmp++;
    if (bus.io_irq !== 1'b0 || bus.io_irq_pending[3] !== 1'b0) begin
      n_bad++; $display("FAIL single_ack got irq=%b pend3=%b exp 0 0", bus.io_irq, bus.io_irq_pending[3]);
    end
    bus.io_irq_src = '0; step(); step(); step();
  endtask

  task automatic test_two_sources();
    bus.io_irq_src = 8'h24;
    for (int i = 0; i < 8 && bus.io_irq !== 1'b1; i++) step();
    n_cmp++;
    if ({bus.io_irq, bus.io_irq_cause} !== {1'b1, CAUSE_W'(2)}) begin
      n_bad++; $display("FAIL two_first got irq=%b cause=%0d exp 1 2", bus.io_irq, bus.io_irq_cause);
    end
    bus.io_irq_ack = 1'b1; step(); bus.io_irq_ack = 1'b0;
    n_cmp++;
    if (bus.io_irq !== 1'b0) begin
      n_bad++; $display("FAIL two_gap got irq=%b exp 0", bus.io_irq);
    end
    step();
    n_cmp++;
    if ({bus.io_irq, bus.io_irq_cause} !== {1'b1, CAUSE_W'(5)}) begin
      n_bad++; $display("FAIL two_second got irq=%b cause=%0d exp 1 5", bus.io_irq, bus.io_irq_cause);
    end
    bus.io_irq_ack = 1'b1; step(); bus.io_irq_ack = 1'b0;
    n_cmp++;
    if (bus.io_irq_pending !== '0 || dut_vec() !== model_vec()) begin
      n_bad++; $display("FAIL two_drained got %h exp %h", dut_vec(), model_vec());
    end
    bus.io_irq_src = '0; step(); step(); step();
  endtask

  task automatic test_disabled();
    bus.io_irq_en = ~8'h02; bus.io_irq_src = 8'h02;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (bus.io_irq !== 1'b0 || bus.io_irq_pending[1] !== 1'b1) begin
      n_bad++; $display("FAIL disabled_pend got irq=%b pend1=%b exp 0 1", bus.io_irq, bus.io_irq_pending[1]);
    end
    bus.io_irq_en = '1;
    for (int i = 0; i < 3 && bus.io_irq !== 1'b1; i++) step();
    n_cmp++;
    if ({bus.io_irq, bus.io_irq_cause} !== {1'b1, CAUSE_W'(1)} || dut_vec() !== model_vec()) begin
      n_bad++; $display("FAIL disabled_enable got %h exp irq=1 cause=1 model %h", dut_vec(), model_vec());
    end
    bus.io_irq_ack = 1'b1; step(); bus.io_irq_ack = 1'b0;
    bus.io_irq_src = '0; step(); step(); step();
  endtask

  task automatic test_withdraw();
    bus.io_irq_src = 8'h10;
    for (int i = 0; i < 8 && bus.io_irq !== 1'b1; i++) step();
    bus.io_irq_en = ~8'h10; step();
    n_cmp++;
    if (bus.io_irq !== 1'b0 || bus.io_irq_pending[4] !== 1'b1) begin
      n_bad++; $display("FAIL withdraw got irq=%b pend4=%b exp 0 1", bus.io_irq, bus.io_irq_pending[4]);
    end
    bus.io_irq_en = '1; step();
    n_cmp++;
    if ({bus.io_irq, bus.io_irq_cause} !== {1'b1, CAUSE_W'(4)}) begin
      n_bad++; $display("FAIL withdraw_repres got irq=%b cause=%0d exp 1 4", bus.io_irq, bus.io_irq_cause);
    end
    bus.io_irq_en = ~8'h10; bus.io_irq_ack = 1'b1; step();
    bus.io_irq_ack = 1'b0; bus.io_irq_en = '1;
    n_cmp++;
    if (bus.io_irq !== 1'b0 || bus.io_irq_pending[4] !== 1'b0) begin
      n_bad++; $display("FAIL ack_over_withdraw got irq=%b pend4=%b exp 0 0", bus.io_irq, bus.io_irq_pending[4]);
    end
  endtask

  task automatic test_back_to_back();
    bus.io_irq_src = '0; step(); step(); step();
    bus.io_irq_src = 8'h10;
    for (int i = 0; i < 8 && bus.io_irq !== 1'b1; i++) step();
    bus.io_irq_src = '0; step(); step(); step();
    bus.io_irq_src = 8'h10;
`ifdef IRQ_PENDING_ARBITER_SYNC_EN
    step(); step();
`endif
    bus.io_irq_ack = 1'b1; step(); bus.io_irq_ack = 1'b0;
    n_cmp++;
    if (bus.io_irq !== 1'b0 || bus.io_irq_pending[4] !== 1'b1) begin
      n_bad++; $display("FAIL rerise_pend got irq=%b pend4=%b exp 0 1", bus.io_irq, bus.io_irq_pending[4]);
    end
    step();
    n_cmp++;
    if ({bus.io_irq, bus.io_irq_cause} !== {1'b1, CAUSE_W'(4)}) begin
      n_bad++; $display("FAIL rerise_repres got irq=%b cause=%0d exp 1 4", bus.io_irq, bus.io_irq_cause);
    end
    bus.io_irq_ack = 1'b1; step(); bus.io_irq_ack = 1'b0;
    bus.io_irq_src = '0; step(); step(); step();
  endtask

  task automatic test_reset_in_hold();
    bus.io_irq_src = 8'hA5;
    for (int i = 0; i < 8 && bus.io_irq !== 1'b1; i++) step();
    n_cmp++;
    if ({bus.io_irq, bus.io_irq_cause, bus.io_irq_pending} !== {1'b1, CAUSE_W'(0), 8'hA5}) begin
      n_bad++; $display("FAIL hold_a5 got %h exp irq=1 cause=0 pend=a5", dut_vec());
    end
    reset = 1'b1; step(); reset = 1'b0;
    n_cmp++;
    if (bus.io_irq !== 1'b0 || bus.io_irq_pending !== '0) begin
      n_bad++; $display("FAIL reset_hold got irq=%b pend=%h exp 0 00", bus.io_irq, bus.io_irq_pending);
    end
    // Lines still high after reset count as fresh edges.
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL post_reset_model got %h exp %h", dut_vec(), model_vec());
      end
    end
    bus.io_irq_src = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) bus.io_irq_src = bus.io_irq_src ^ NSRC'($urandom);
      if ($urandom_range(0, 7) == 0) bus.io_irq_en = ($urandom_range(0, 1) == 0) ? '1 : NSRC'($urandom);
      bus.io_irq_ack = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 79) == 0);
      step();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL random cyc=%0d got %h exp %h", i, dut_vec(), model_vec());
      end
    end
    reset = 1'b0; bus.io_irq_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_sources();
    test_disabled();
    test_withdraw();
    test_back_to_back();
    test_reset_in_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_irq_pending_arbiter
